multi_stage_sync: RTL and testbench
===================================

MULTI_STAGE_SYNC -- requirements
Module: multi_stage_sync

Interface
REQ-001 Parameter BUS_WIDTH, default 8: number of independent single-bit channels synchronised.
REQ-002 Parameter NUM_STAGES, default 2: flops per channel synchroniser chain; legal range 2..4.
REQ-003 Parameter FILTER_CYCLES, default 3: consecutive cycles a synchronised value must hold before it is accepted; legal range 1..15.
REQ-004 CLK  input  1  destination clock; all state updates on rising edge.
REQ-005 RST  input  1  one clock; reset is synchronous and active-high (sampled on CLK rising edge).
REQ-006 ASYNC_IN  input  BUS_WIDTH  asynchronous level inputs, one per channel, no timing relation to CLK.
REQ-007 SYNC_OUT  output  BUS_WIDTH  last stage of each synchroniser chain (unfiltered).
REQ-008 FILT_OUT  output  BUS_WIDTH  debounced/accepted level per channel, registered.
REQ-009 RISE_PULSE  output  BUS_WIDTH  one-cycle strobe per channel on FILT_OUT 0->1.
REQ-010 FALL_PULSE  output  BUS_WIDTH  one-cycle strobe per channel on FILT_OUT 1->0.
REQ-011 ANY_CHANGE  output  1  registered OR of all RISE_PULSE and FALL_PULSE bits for the same cycle.

Function
REQ-012 Each channel SHALL have a private NUM_STAGES-deep shift chain; stage 0 samples ASYNC_IN[i] every edge, stage n takes stage n-1.
REQ-013 SYNC_OUT[i] SHALL equal the final chain stage; a level stable before edge k appears on SYNC_OUT after edge k+NUM_STAGES-1.
REQ-014 No combinational path SHALL exist from ASYNC_IN to any output; stage 0 output SHALL feed only stage 1.
REQ-015 Each channel SHALL have a filter counter of 4 bits; channels SHALL be fully independent.
REQ-016 At an edge where SYNC_OUT[i] == FILT_OUT[i]: counter cleared to 0, FILT_OUT held.
REQ-017 At an edge where SYNC_OUT[i] != FILT_OUT[i] and counter < FILTER_CYCLES-1: counter increments, FILT_OUT held.
REQ-018 At an edge where SYNC_OUT[i] != FILT_OUT[i] and counter == FILTER_CYCLES-1: FILT_OUT[i] <= SYNC_OUT[i], counter cleared.
REQ-019 Consequently FILT_OUT follows a stable input after edge k+NUM_STAGES-1+FILTER_CYCLES; with FILTER_CYCLES=1 it lags SYNC_OUT by exactly one cycle.
REQ-020 A SYNC_OUT deviation shorter than FILTER_CYCLES cycles SHALL leave FILT_OUT and pulses unchanged; the counter restarts from 0 on any return to agreement.
REQ-021 RISE_PULSE[i] SHALL be high for exactly the one cycle in which FILT_OUT[i] first reads 1 after reading 0; FALL_PULSE likewise for 1->0; never both on one channel.
REQ-022 ANY_CHANGE SHALL be high in the same cycle as any asserted RISE_PULSE or FALL_PULSE bit, low otherwise.
REQ-023 Simultaneous transitions on multiple channels SHALL produce simultaneous, per-channel correct pulses.

Reset
REQ-024 While RST is high at an edge: all chain stages, SYNC_OUT, FILT_OUT, filter counters, RISE_PULSE, FALL_PULSE, ANY_CHANGE SHALL load 0.
REQ-025 Reset mid-filter SHALL discard partial counts; after release, counting restarts from 0.
REQ-026 The first FILT_OUT rise after reset SHALL generate RISE_PULSE (reset value 0 is treated as the prior level); no pulses SHALL occur during or due to reset itself.

Verification (BUS_WIDTH=8, NUM_STAGES=2, FILTER_CYCLES=3 unless stated)
REQ-027 Reset: ASYNC_IN=8'hFF, RST high 3 cycles -> all outputs 0 throughout; first low edge k -> SYNC_OUT=8'hFF after k+1, FILT_OUT=8'hFF and RISE_PULSE=8'hFF, ANY_CHANGE=1 after k+4, pulses 0 after k+5.
REQ-028 Glitch reject: ASYNC_IN[0] high 2 cycles then low -> SYNC_OUT[0] high 2 cycles, FILT_OUT[0], RISE_PULSE[0], ANY_CHANGE stay 0.
REQ-029 Fall: from FILT_OUT=8'h0F, ASYNC_IN=8'h05 -> FALL_PULSE=8'h0A one cycle, FILT_OUT=8'h05, RISE_PULSE=0.
REQ-030 Mixed: ASYNC_IN 8'h00->8'hA5 while bit 7 toggles back after 1 SYNC cycle -> FILT_OUT=8'h25, RISE_PULSE=8'h25 one cycle.
REQ-031 Reset mid-count: SYNC_OUT[3] differs for 2 cycles, RST pulsed 1 cycle, input held -> FILT_OUT[3] updates 3 cycles after SYNC_OUT[3] re-establishes, not earlier.
REQ-032 Parameter sweep: NUM_STAGES=3, FILTER_CYCLES=1, step ASYNC_IN[2] before edge k -> SYNC_OUT[2] after k+2, FILT_OUT[2] and RISE_PULSE[2] after k+3.

Source files
------------

// File: rtl/multi_stage_sync.sv
// Per-channel multi-flop synchroniser with a hold-time filter and edge strobes.
// Every output is driven straight from a flop clocked by CLK.
module multi_stage_sync #(
  parameter int BUS_WIDTH     = 8,
  parameter int NUM_STAGES    = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] ASYNC_IN,
  output logic [BUS_WIDTH-1:0] SYNC_OUT,
  output logic [BUS_WIDTH-1:0] FILT_OUT,
  output logic [BUS_WIDTH-1:0] RISE_PULSE,
  output logic [BUS_WIDTH-1:0] FALL_PULSE,
  output logic                 ANY_CHANGE
);

  localparam logic [3:0] CNT_LAST = 4'(FILTER_CYCLES - 1);

  // Bit 0 is the metastable capture flop; bit NUM_STAGES-1 is the settled value.
  logic [NUM_STAGES-1:0] chain_q [BUS_WIDTH];
  logic [3:0]            cnt_q   [BUS_WIDTH];

  logic [BUS_WIDTH-1:0] accept;
  logic [BUS_WIDTH-1:0] rise_d;
  logic [BUS_WIDTH-1:0] fall_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < BUS_WIDTH; i++) begin
        chain_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < BUS_WIDTH; i++) begin
        chain_q[i] <= {chain_q[i][NUM_STAGES-2:0], ASYNC_IN[i]};
      end
    end
  end

  always_comb begin
    SYNC_OUT = '0;
    for (int i = 0; i < BUS_WIDTH; i++) begin
      SYNC_OUT[i] = chain_q[i][NUM_STAGES-1];
    end
  end

  // A channel is accepted on the edge where it has disagreed for FILTER_CYCLES edges.
  always_comb begin
    accept = '0;
    for (int i = 0; i < BUS_WIDTH; i++) begin
      accept[i] = (SYNC_OUT[i] != FILT_OUT[i]) && (cnt_q[i] == CNT_LAST);
    end
    rise_d = accept & SYNC_OUT;
    fall_d = accept & ~SYNC_OUT;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      FILT_OUT <= '0;
      for (int i = 0; i < BUS_WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < BUS_WIDTH; i++) begin
        if (SYNC_OUT[i] == FILT_OUT[i]) begin
          cnt_q[i] <= '0;
        end else if (accept[i]) begin
          cnt_q[i]    <= '0;
          FILT_OUT[i] <= SYNC_OUT[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + 4'd1;
        end
      end
    end
  end

  // Strobes are registered alongside FILT_OUT so they coincide with the new level.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RISE_PULSE <= '0;
      FALL_PULSE <= '0;
      ANY_CHANGE <= 1'b0;
    end else begin
      RISE_PULSE <= rise_d;
      FALL_PULSE <= fall_d;
      ANY_CHANGE <= |(rise_d | fall_d);
    end
  end

endmodule

// File: tb/tb_multi_stage_sync.sv
// Directed bench for multi_stage_sync: default build plus a NUM_STAGES=3,
// FILTER_CYCLES=1 build sharing clock and reset.
module tb_multi_stage_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] async_in;
  logic [7:0] sync_out, filt_out, rise_pulse, fall_pulse;
  logic       any_change;
  logic [7:0] async_fast;
  logic [7:0] sync_fast, filt_fast, rise_fast, fall_fast;
  logic       any_fast;

  logic [39:0] exp_q[$];
  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  multi_stage_sync u_dut (
    .CLK        (clk),
    .RST        (rst),
    .ASYNC_IN   (async_in),
    .SYNC_OUT   (sync_out),
    .FILT_OUT   (filt_out),
    .RISE_PULSE (rise_pulse),
    .FALL_PULSE (fall_pulse),
    .ANY_CHANGE (any_change)
  );

  multi_stage_sync #(.BUS_WIDTH(8), .NUM_STAGES(3), .FILTER_CYCLES(1)) u_fast (
    .CLK        (clk),
    .RST        (rst),
    .ASYNC_IN   (async_fast),
    .SYNC_OUT   (sync_fast),
    .FILT_OUT   (filt_fast),
    .RISE_PULSE (rise_fast),
    .FALL_PULSE (fall_fast),
    .ANY_CHANGE (any_fast)
  );

  function automatic logic [39:0] ev(input logic [7:0] s, input logic [7:0] f,
                                     input logic [7:0] r, input logic [7:0] fl,
                                     input logic a);
    return {7'b0, a, fl, r, f, s};
  endfunction

  function automatic logic [39:0] obs_main();
    return ev(sync_out, filt_out, rise_pulse, fall_pulse, any_change);
  endfunction

  function automatic logic [39:0] obs_fast();
    return ev(sync_fast, filt_fast, rise_fast, fall_fast, any_fast);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_cmp(input string tag, input logic [39:0] obs);
    logic [39:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_mis++;
      $display("FAIL %s: scoreboard empty, observed=%h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_mis++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic run_main(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      pop_cmp($sformatf("%s[%0d]", tag, i), obs_main());
    end
  endtask

  task automatic run_fast(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      pop_cmp($sformatf("%s[%0d]", tag, i), obs_fast());
    end
  endtask

  // Standard settle window for the default build: input v driven from level p.
  task automatic push_step(input logic [7:0] p, input logic [7:0] v);
    exp_q.push_back(ev(p, p, 8'h00, 8'h00, 1'b0));
    for (int i = 0; i < 3; i++) exp_q.push_back(ev(v, p, 8'h00, 8'h00, 1'b0));
    exp_q.push_back(ev(v, v, v & ~p, p & ~v, v != p));
    exp_q.push_back(ev(v, v, 8'h00, 8'h00, 1'b0));
  endtask

  initial begin
    logic [7:0] prev, v;

    rst        = 1'b1;
    async_in   = 8'hFF;
    async_fast = 8'h00;
    for (int i = 0; i < 3; i++) exp_q.push_back(ev(8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
    run_main("reset_hold", 3);

    rst = 1'b0;
    push_step(8'h00, 8'hFF);
    run_main("reset_release", 6);

    rst      = 1'b1;
    async_in = 8'h00;
    exp_q.push_back(ev(8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
    run_main("reset_clear_no_pulse", 1);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) exp_q.push_back(ev(8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
    run_main("idle", 2);

    async_in = 8'h01;
    exp_q.push_back(ev(8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
    exp_q.push_back(ev(8'h01, 8'h00, 8'h00, 8'h00, 1'b0));
    run_main("glitch_hi", 2);
    async_in = 8'h00;
    exp_q.push_back(ev(8'h01, 8'h00, 8'h00, 8'h00, 1'b0));
    for (int i = 0; i < 3; i++) exp_q.push_back(ev(8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
    run_main("glitch_reject", 4);

    async_in = 8'h0F;
    push_step(8'h00, 8'h0F);
    run_main("rise_0f", 6);
    async_in = 8'h05;
    push_step(8'h0F, 8'h05);
    run_main("fall_0a", 6);
    async_in = 8'h00;
    push_step(8'h05, 8'h00);
    run_main("fall_05", 6);

    async_in = 8'hA5;
    exp_q.push_back(ev(8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
    run_main("mixed_a5", 1);
    async_in = 8'h25;
    exp_q.push_back(ev(8'hA5, 8'h00, 8'h00, 8'h00, 1'b0));
    exp_q.push_back(ev(8'h25, 8'h00, 8'h00, 8'h00, 1'b0));
    exp_q.push_back(ev(8'h25, 8'h00, 8'h00, 8'h00, 1'b0));
    exp_q.push_back(ev(8'h25, 8'h25, 8'h25, 8'h00, 1'b1));
    exp_q.push_back(ev(8'h25, 8'h25, 8'h00, 8'h00, 1'b0));
    run_main("mixed_bit7_drop", 5);

    async_in = 8'h2D;
    exp_q.push_back(ev(8'h25, 8'h25, 8'h00, 8'h00, 1'b0));
    for (int i = 0; i < 3; i++) exp_q.push_back(ev(8'h2D, 8'h25, 8'h00, 8'h00, 1'b0));
    run_main("midcount", 4);
    rst = 1'b1;
    exp_q.push_back(ev(8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
    run_main("midcount_reset", 1);
    rst = 1'b0;
    exp_q.push_back(ev(8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
    for (int i = 0; i < 3; i++) exp_q.push_back(ev(8'h2D, 8'h00, 8'h00, 8'h00, 1'b0));
    exp_q.push_back(ev(8'h2D, 8'h2D, 8'h2D, 8'h00, 1'b1));
    exp_q.push_back(ev(8'h2D, 8'h2D, 8'h00, 8'h00, 1'b0));
    run_main("midcount_restart", 6);

    prev = 8'h2D;
    for (int n = 0; n < 6; n++) begin
      v        = 8'($urandom_range(0, 255));
      async_in = v;
      push_step(prev, v);
      run_main($sformatf("random%0d_%h", n, v), 6);
      prev = v;
    end

    async_fast = 8'h04;
    exp_q.push_back(ev(8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
    exp_q.push_back(ev(8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
    exp_q.push_back(ev(8'h04, 8'h00, 8'h00, 8'h00, 1'b0));
    exp_q.push_back(ev(8'h04, 8'h04, 8'h04, 8'h00, 1'b1));
    exp_q.push_back(ev(8'h04, 8'h04, 8'h00, 8'h00, 1'b0));
    run_main_skip: begin end
    run_fast("fast_rise", 5);
    async_fast = 8'h00;
    exp_q.push_back(ev(8'h04, 8'h04, 8'h00, 8'h00, 1'b0));
    exp_q.push_back(ev(8'h04, 8'h04, 8'h00, 8'h00, 1'b0));
    exp_q.push_back(ev(8'h00, 8'h04, 8'h00, 8'h00, 1'b0));
    exp_q.push_back(ev(8'h00, 8'h00, 8'h00, 8'h04, 1'b1));
    exp_q.push_back(ev(8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
    run_fast("fast_fall", 5);

    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_mis++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
